program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Upstream neighbour of the CPU; replaces the fixed instruction ROM.
- Receives a program as a byte stream over a valid/ready handshake and writes 16-bit instruction words into an internal RAM.
- Holds the CPU in reset until loading is complete.
- In RUN, serves the CPU's instruction fetch combinationally from pc, exactly as a ROM would.

Parameters:
- INSTRUCTION_WIDTH, 16, instruction word width; must equal 16 (two bytes per word).
- PC_WIDTH, 8, RAM address width; depth = 2**PC_WIDTH.
- BYTE_WIDTH, 8, width of the stream byte.

Ports:
- clock  in  1  single system clock, rising edge.
- isReset  in  1  asynchronous, active-high reset.
- byteIn  in  8  stream data byte.
- byteValid  in  1  byteIn is valid this cycle.
- byteReady  out  1  loader can accept a byte this cycle.
- reload  in  1  single-cycle pulse: discard the running program and load a new one.
- pc  in  PC_WIDTH  fetch address from the CPU.
- instruction  out  16  instruction at pc.
- cpuReset  out  1  drives the CPU's isReset; high while not in RUN.
- loadDone  out  1  high in RUN.
- wordCount  out  PC_WIDTH+1  count of words written in the current load.
- loadError  out  1  checksum failure (sticky until reset or reload).

Interface (already decided): one clock, named clock; reset isReset is asynchronous and active-high.

Behaviour:
- Reset values: state=LEN, byteReady=1, cpuReset=1, loadDone=0, wordCount=0, loadError=0, write address=0.
- RAM contents are not cleared by reset.
- A byte transfers on a rising edge with byteValid && byteReady. byteReady is combinational from state only:
  - 1 in LEN, HI, LO, CHK.
  - 0 in REL, RUN, ERR.
- States and transitions:
  - LEN: the accepted byte L is the word count; L=0 means 2**PC_WIDTH words. Latch target, clear addr and wordCount, go to HI.
  - HI: latch the accepted byte as the high byte; go to LO.
  - LO: write {hi, byte} to mem[addr]; addr+1; wordCount+1. If wordCount+1 == target, go to CHK (macro defined) or REL; otherwise go to HI.
  - CHK: accept the checksum byte. Match goes to REL; mismatch goes to ERR with loadError=1.
  - REL: one cycle with cpuReset still high, so the CPU's synchronous reset sets pc=0 and clears the accumulator and stack. Then go to RUN.
  - RUN: cpuReset=0, loadDone=1. A byteValid that arrives here is ignored (not accepted).
  - ERR: cpuReset held at 1. Only isReset or reload leaves this state.
- reload, sampled in any state other than LEN, goes to LEN next cycle:
  - cpuReset=1 immediately (combinational from state, asserted from the next cycle onward).
  - wordCount and loadError clear.
  - A byte offered in the same cycle as reload is not accepted.
- Async reset mid-load: return to LEN. Partially written RAM is retained but never executed until a complete load finishes.
- Read path: instruction = mem[pc] combinationally in RUN. It is forced to 0 whenever cpuReset=1, so opcode 0 (LOAD0) is harmless.
- Write address wraps modulo 2**PC_WIDTH. A full-depth load ends with addr=0 and wordCount=2**PC_WIDTH.
- A read of an address that has not been written returns stale or X; the bench must not check it.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined: a running XOR of all instruction bytes (hi and lo) is kept, cleared in LEN. One trailing checksum byte is expected and compared in CHK.
- Undefined: the CHK state, the checksum register and the ERR path are absent; loadError is tied to 0. The stream is exactly 1+2L bytes.

Decomposition:
- Shared package loader_pkg holds:
  - the state enum (LEN, HI, LO, CHK, REL, RUN, ERR);
  - the BYTE_WIDTH constant;
  - the RESET4 opcode constant, for the bench.
- One sub-module, instruction_ram: synchronous write port (we, waddr, wdata), asynchronous read port (raddr, rdata), depth 2**PC_WIDTH. The CPU's fetch reads through this port.

Test Plan:
- Stream 02, 00 05, 30 07 (plus checksum 32 with macro) → RUN after REL. mem[0]=0x0005, mem[1]=0x3007, wordCount=2. cpuReset falls exactly 1 cycle after the last byte is accepted. pc=1 gives instruction=0x3007.
- Same stream with byteValid toggled every other cycle, plus an extra byte AA offered in RUN → identical RAM, byteReady=0 in RUN, AA not accepted.
- With macro, stream 01, 12 34, checksum 00 (correct value is 26) → ERR, loadError=1, cpuReset stays 1, instruction=0.
- isReset asserted after byte 3 of a 5-byte stream → state LEN and cpuReset=1 the same cycle. A fresh complete load then reaches RUN normally.
- Length byte 00 followed by 512 bytes → wordCount=256, addr wraps to 0, last word lands in mem[255].
- reload pulse in RUN → cpuReset=1 the next cycle, loadDone=0, byteReady=1. A new 1-word load 01, 40 00 sets mem[0]=0x4000 and returns to RUN.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader and its bench.
package loader_pkg;

  localparam int unsigned BYTE_WIDTH = 8;

  // CPU opcode nibble for RESET4, placed in the top four bits of an instruction.
  localparam logic [3:0] RESET4 = 4'h4;

  typedef enum logic [2:0] {
    ST_LEN,
    ST_HI,
    ST_LO,
    ST_CHK,
    ST_REL,
    ST_RUN,
    ST_ERR
  } state_e;

endpackage

// File: rtl/program_loader_ram.sv
// Instruction store: synchronous write, asynchronous read, never cleared.
module instruction_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader that replaces the instruction ROM and holds the CPU in reset.
// Optional trailing XOR checksum enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned INSTRUCTION_WIDTH = 16,
  parameter int unsigned PC_WIDTH          = 8,
  parameter int unsigned BYTE_WIDTH        = loader_pkg::BYTE_WIDTH
) (
  input  logic                         clock,
  input  logic                         isReset,
  input  logic [BYTE_WIDTH-1:0]        byteIn,
  input  logic                         byteValid,
  output logic                         byteReady,
  input  logic                         reload,
  input  logic [PC_WIDTH-1:0]          pc,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         cpuReset,
  output logic                         loadDone,
  output logic [PC_WIDTH:0]            wordCount,
  output logic                         loadError
);

  import loader_pkg::*;

  state_e                       state_q;
  logic [BYTE_WIDTH-1:0]        hi_q;
  logic [PC_WIDTH-1:0]          addr_q;
  logic [PC_WIDTH:0]            count_q;
  logic [PC_WIDTH:0]            target_q;
  logic [PC_WIDTH:0]            count_d;
  logic [PC_WIDTH:0]            len_words;
  logic                         reload_take;
  logic                         accept;
  logic                         we;
  logic [INSTRUCTION_WIDTH-1:0] rdata;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0]        chk_q;
  logic                         err_q;
`endif

  assign byteReady   = (state_q == ST_LEN) || (state_q == ST_HI) ||
                       (state_q == ST_LO)  || (state_q == ST_CHK);
  assign cpuReset    = (state_q != ST_RUN);
  assign loadDone    = (state_q == ST_RUN);
  assign wordCount   = count_q;
  // reload wins over a byte offered in the same cycle, except in LEN where it is ignored.
  assign reload_take = reload && (state_q != ST_LEN);
  assign accept      = byteValid && byteReady && !reload_take;
  assign we          = accept && (state_q == ST_LO);
  assign count_d     = count_q + 1'b1;

  always_comb begin
    len_words = (PC_WIDTH+1)'(byteIn);
    if (byteIn == '0) len_words = (PC_WIDTH+1)'(1) << PC_WIDTH;
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign loadError = err_q;
`else
  assign loadError = 1'b0;
`endif

  always_ff @(posedge clock or posedge isReset) begin
    if (isReset) begin
      state_q  <= ST_LEN;
      hi_q     <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      target_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else if (reload_take) begin
      state_q <= ST_LEN;
      count_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_LEN: if (accept) begin
          target_q <= len_words;
          addr_q   <= '0;
          count_q  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          chk_q    <= '0;
`endif
          state_q  <= ST_HI;
        end
        ST_HI: if (accept) begin
          hi_q    <= byteIn;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          chk_q   <= chk_q ^ byteIn;
`endif
          state_q <= ST_LO;
        end
        ST_LO: if (accept) begin
          addr_q  <= addr_q + 1'b1;
          count_q <= count_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          chk_q   <= chk_q ^ byteIn;
          state_q <= (count_d == target_q) ? ST_CHK : ST_HI;
`else
          state_q <= (count_d == target_q) ? ST_REL : ST_HI;
`endif
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_CHK: if (accept) begin
          if (byteIn == chk_q) begin
            state_q <= ST_REL;
          end else begin
            err_q   <= 1'b1;
            state_q <= ST_ERR;
          end
        end
        ST_ERR: state_q <= ST_ERR;
`endif
        ST_REL: state_q <= ST_RUN;
        ST_RUN: state_q <= ST_RUN;
        default: state_q <= ST_LEN;
      endcase
    end
  end

  instruction_ram #(
    .DATA_WIDTH(INSTRUCTION_WIDTH),
    .ADDR_WIDTH(PC_WIDTH)
  ) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (addr_q),
    .wdata ({hi_q, byteIn}),
    .raddr (pc),
    .rdata (rdata)
  );

  assign instruction = cpuReset ? '0 : rdata;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; follows PROGRAM_LOADER_CHECKSUM_EN for stream format.
module tb_program_loader;
  import loader_pkg::*;

  localparam int unsigned PCW = 8;

  logic           clock = 1'b0;
  logic           isReset;
  logic [7:0]     byteIn;
  logic           byteValid;
  logic           byteReady;
  logic           reload;
  logic [PCW-1:0] pc;
  logic [15:0]    instruction;
  logic           cpuReset;
  logic           loadDone;
  logic [PCW:0]   wordCount;
  logic           loadError;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  program_loader #(
    .INSTRUCTION_WIDTH(16),
    .PC_WIDTH(PCW),
    .BYTE_WIDTH(8)
  ) dut (
    .clock       (clock),
    .isReset     (isReset),
    .byteIn      (byteIn),
    .byteValid   (byteValid),
    .byteReady   (byteReady),
    .reload      (reload),
    .pc          (pc),
    .instruction (instruction),
    .cpuReset    (cpuReset),
    .loadDone    (loadDone),
    .wordCount   (wordCount),
    .loadError   (loadError)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned w;
    byteIn    = b;
    byteValid = 1'b1;
    w = 0;
    while (!byteReady && w < 20) begin
      tick();
      w++;
    end
    if (w == 20) check("ready_timeout", {31'b0, byteReady}, 32'd1);
    tick();
    byteValid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit gap);
    foreach (s[i]) begin
      send_byte(s[i]);
      if (gap) begin
        byteIn = 8'hEE;
        tick();
      end
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic read_at(input logic [PCW-1:0] a, input string tag, input logic [15:0] exp);
    pc = a;
    #1;
    check(tag, {16'b0, instruction}, {16'b0, exp});
  endtask

  logic [7:0] s[$];

  initial begin
    isReset   = 1'b1;
    byteIn    = '0;
    byteValid = 1'b0;
    reload    = 1'b0;
    pc        = '0;
    #2;
    check("rst_byteReady", {31'b0, byteReady}, 32'd1);
    check("rst_cpuReset",  {31'b0, cpuReset},  32'd1);
    check("rst_loadDone",  {31'b0, loadDone},  32'd0);
    check("rst_wordCount", {23'b0, wordCount}, 32'd0);
    check("rst_loadError", {31'b0, loadError}, 32'd0);
    check("rst_instr",     {16'b0, instruction}, 32'd0);
    #10;
    isReset = 1'b0;
    tick();

    // Basic two-word load
    s = '{8'h02, 8'h00, 8'h05, 8'h30, 8'h07};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    s.push_back(8'h32);
`endif
    send_stream(s, 1'b0);
    check("rel_cpuReset",  {31'b0, cpuReset},  32'd1);
    check("rel_byteReady", {31'b0, byteReady}, 32'd0);
    check("rel_loadDone",  {31'b0, loadDone},  32'd0);
    check("rel_wordCount", {23'b0, wordCount}, 32'd2);
    tick();
    check("run_cpuReset",  {31'b0, cpuReset},  32'd0);
    check("run_loadDone",  {31'b0, loadDone},  32'd1);
    check("run_loadError", {31'b0, loadError}, 32'd0);
    read_at(8'd0, "basic_mem0", 16'h0005);
    read_at(8'd1, "basic_mem1", 16'h3007);

    // Same stream with byteValid toggling, then a byte offered in RUN
    pulse_reload();
    send_stream(s, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    byteIn    = 8'hAA;
    byteValid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("run_byteReady", {31'b0, byteReady}, 32'd0);
    check("aa_loadDone",   {31'b0, loadDone},  32'd1);
    check("aa_wordCount",  {23'b0, wordCount}, 32'd2);
    byteValid = 1'b0;
    read_at(8'd0, "gap_mem0", 16'h0005);
    read_at(8'd1, "gap_mem1", 16'h3007);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Wrong checksum (correct value 0x26)
    pulse_reload();
    s = '{8'h01, 8'h12, 8'h34, 8'h00};
    send_stream(s, 1'b0);
    check("err_loadError", {31'b0, loadError}, 32'd1);
    check("err_byteReady", {31'b0, byteReady}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("err_cpuReset",  {31'b0, cpuReset},  32'd1);
    check("err_loadDone",  {31'b0, loadDone},  32'd0);
    read_at(8'd0, "err_instr", 16'h0000);
    pulse_reload();
    check("errrl_loadError", {31'b0, loadError}, 32'd0);
    check("errrl_byteReady", {31'b0, byteReady}, 32'd1);
`endif

    // Asynchronous reset after byte 3 of a 5-byte stream
    pulse_reload();
    s = '{8'h02, 8'h11, 8'h22};
    send_stream(s, 1'b0);
    #2;
    isReset = 1'b1;
    #1;
    check("arst_byteReady", {31'b0, byteReady}, 32'd1);
    check("arst_cpuReset",  {31'b0, cpuReset},  32'd1);
    check("arst_wordCount", {23'b0, wordCount}, 32'd0);
    #4;
    isReset = 1'b0;
    tick();
    s = '{8'h01, 8'hAB, 8'hCD};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    s.push_back(8'h66);
`endif
    send_stream(s, 1'b0);
    tick();
    check("arst_run",       {31'b0, loadDone},  32'd1);
    check("arst_wordCount2",{23'b0, wordCount}, 32'd1);
    read_at(8'd0, "arst_mem0", 16'hABCD);

    // Full-depth load: length 0, word i = {i, i^A5}, checksum 00
    pulse_reload();
    s = '{8'h00};
    for (int i = 0; i < 256; i++) begin
      s.push_back(8'(i));
      s.push_back(8'(i) ^ 8'hA5);
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    s.push_back(8'h00);
`endif
    send_stream(s, 1'b0);
    check("full_wordCount", {23'b0, wordCount}, 32'h100);
    tick();
    check("full_run", {31'b0, loadDone}, 32'd1);
    read_at(8'd0,   "full_mem0",   16'h00A5);
    read_at(8'd128, "full_mem128", 16'h8025);
    read_at(8'd255, "full_mem255", 16'hFF5A);

    // reload from RUN, then a one-word RESET4 program
    byteIn    = 8'h05;
    byteValid = 1'b1;
    pulse_reload();
    byteValid = 1'b0;
    check("rl_cpuReset",  {31'b0, cpuReset},  32'd1);
    check("rl_loadDone",  {31'b0, loadDone},  32'd0);
    check("rl_byteReady", {31'b0, byteReady}, 32'd1);
    check("rl_wordCount", {23'b0, wordCount}, 32'd0);
    check("rl_instr",     {16'b0, instruction}, 32'd0);
    s = '{8'h01, {RESET4, 4'h0}, 8'h00};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    s.push_back(8'h40);
`endif
    send_stream(s, 1'b0);
    tick();
    check("rl_run",        {31'b0, loadDone},  32'd1);
    check("rl_wordCount1", {23'b0, wordCount}, 32'd1);
    read_at(8'd0, "rl_mem0", 16'h4000);
    read_at(8'd1, "rl_mem1_kept", 16'h01A4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
